// File: rtl/decode_stage_if.sv
// Fetch/decode/execute handshake bundle for decode_stage.
// master: upstream driver (fetch side plus out_ready/flush); slave: the stage.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr_in;
  logic [XLEN-1:0] pc_in;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] pc_out;
  logic [4:0]      rs1_addr_out;
  logic [4:0]      rs2_addr_out;
  logic [4:0]      rd_addr_out;
  logic            rs1_read_out;
  logic            rs2_read_out;
  logic            rd_write_out;
  logic [XLEN-1:0] imm_out;
  logic [2:0]      imm_sel_out;
  logic [6:0]      alu_op_out;
  logic [2:0]      funct3_out;
  logic            alu_sub_sra_out;
  logic [1:0]      alu_src1_out;
  logic [1:0]      alu_src2_out;
  logic            mem_read_out;
  logic            mem_write_out;
  logic            branch_out;
  logic            jump_out;
  logic            muldiv_out;
  logic            illegal_out;

  modport master (
    output flush, in_valid, instr_in, pc_in, out_ready,
    input  in_ready, out_valid, pc_out,
    input  rs1_addr_out, rs2_addr_out, rd_addr_out,
    input  rs1_read_out, rs2_read_out, rd_write_out,
    input  imm_out, imm_sel_out, alu_op_out, funct3_out,
    input  alu_sub_sra_out, alu_src1_out, alu_src2_out,
    input  mem_read_out, mem_write_out, branch_out,
    input  jump_out, muldiv_out, illegal_out
  );

  modport slave (
    input  flush, in_valid, instr_in, pc_in, out_ready,
    output in_ready, out_valid, pc_out,
    output rs1_addr_out, rs2_addr_out, rd_addr_out,
    output rs1_read_out, rs2_read_out, rd_write_out,
    output imm_out, imm_sel_out, alu_op_out, funct3_out,
    output alu_sub_sra_out, alu_src1_out, alu_src2_out,
    output mem_read_out, mem_write_out, branch_out,
    output jump_out, muldiv_out, illegal_out
  );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I/M decode stage with load-use bubble and flush.
// Ports: clk, reset (sync, active-high), io (decode_stage_if.slave).
module decode_stage #(
  parameter int XLEN            = 32,
  parameter int ENABLE_M        = 1,
  parameter int ENABLE_LU_STALL = 1
) (
  input logic          clk,
  input logic          reset,
  decode_stage_if.slave io
);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rs1_read;
    logic            rs2_read;
    logic            rd_write;
    logic [XLEN-1:0] imm;
    logic [2:0]      imm_sel;
    logic [6:0]      alu_op;
    logic [2:0]      funct3;
    logic            sub_sra;
    logic [1:0]      src1;
    logic [1:0]      src2;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            muldiv;
    logic            illegal;
  } ctrl_t;

  ctrl_t      ctrl_q, ctrl_d, dec;
  logic       hold_q, hold_d;
  logic       ld_pend_q, ld_pend_d;
  logic [4:0] ld_rd_q, ld_rd_d;
  logic       hazard, accept, fire;

  logic [31:0] ins;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [31:0] imm32;
  logic        legal;

  assign ins = io.instr_in;
  assign opc = ins[6:0];
  assign f3  = ins[14:12];
  assign f7  = ins[31:25];

  logic is_lui, is_auipc, is_jal, is_jalr;
  logic is_br, is_ld, is_st, is_opi, is_op;

  assign is_lui   = opc == 7'b0110111;
  assign is_auipc = opc == 7'b0010111;
  assign is_jal   = opc == 7'b1101111;
  assign is_jalr  = opc == 7'b1100111;
  assign is_br    = opc == 7'b1100011;
  assign is_ld    = opc == 7'b0000011;
  assign is_st    = opc == 7'b0100011;
  assign is_opi   = opc == 7'b0010011;
  assign is_op    = opc == 7'b0110011;

  // Every opcode constant ends in 2'b11, so
  // other low bits fall through as illegal.
  always_comb begin
    dec        = '0;
    dec.pc     = io.pc_in;
    dec.rs1    = ins[19:15];
    dec.rs2    = ins[24:20];
    dec.rd     = ins[11:7];
    dec.alu_op = opc;
    dec.funct3 = f3;
    legal      = 1'b0;
    imm32      = '0;
    unique case (1'b1)
      is_lui: begin
        legal        = 1'b1;
        dec.rd_write = 1'b1;
        dec.src1     = 2'd2;
        dec.src2     = 2'd1;
        dec.imm_sel  = 3'd4;
        imm32        = {ins[31:12], 12'b0};
      end
      is_auipc: begin
        legal        = 1'b1;
        dec.rd_write = 1'b1;
        dec.src1     = 2'd1;
        dec.src2     = 2'd1;
        dec.imm_sel  = 3'd4;
        imm32        = {ins[31:12], 12'b0};
      end
      is_jal: begin
        legal        = 1'b1;
        dec.rd_write = 1'b1;
        dec.jump     = 1'b1;
        dec.src1     = 2'd1;
        dec.src2     = 2'd2;
        dec.imm_sel  = 3'd5;
        imm32 = {{12{ins[31]}}, ins[19:12],
                 ins[20], ins[30:21], 1'b0};
      end
      is_jalr: begin
        legal        = f3 == 3'd0;
        dec.rs1_read = 1'b1;
        dec.rd_write = 1'b1;
        dec.jump     = 1'b1;
        dec.src1     = 2'd1;
        dec.src2     = 2'd2;
        dec.imm_sel  = 3'd1;
        imm32        = {{20{ins[31]}}, ins[31:20]};
      end
      is_br: begin
        legal        = f3 != 3'd2 && f3 != 3'd3;
        dec.rs1_read = 1'b1;
        dec.rs2_read = 1'b1;
        dec.branch   = 1'b1;
        dec.sub_sra  = 1'b1;
        dec.imm_sel  = 3'd3;
        imm32 = {{20{ins[31]}}, ins[7],
                 ins[30:25], ins[11:8], 1'b0};
      end
      is_ld: begin
        legal = f3 != 3'd3 && f3 != 3'd6
             && f3 != 3'd7;
        dec.rs1_read = 1'b1;
        dec.rd_write = 1'b1;
        dec.mem_read = 1'b1;
        dec.src2     = 2'd1;
        dec.imm_sel  = 3'd1;
        imm32        = {{20{ins[31]}}, ins[31:20]};
      end
      is_st: begin
        legal         = f3 <= 3'd2;
        dec.rs1_read  = 1'b1;
        dec.rs2_read  = 1'b1;
        dec.mem_write = 1'b1;
        dec.src2      = 2'd1;
        dec.imm_sel   = 3'd2;
        imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      is_opi: begin
        dec.rs1_read = 1'b1;
        dec.rd_write = 1'b1;
        dec.src2     = 2'd1;
        dec.imm_sel  = 3'd1;
        // Shifts carry only the shamt as immediate.
        if (f3 == 3'd1) begin
          legal = f7 == 7'd0;
          imm32 = {27'd0, ins[24:20]};
        end else if (f3 == 3'd5) begin
          legal = f7 == 7'd0 || f7 == 7'b0100000;
          dec.sub_sra = f7[5];
          imm32 = {27'd0, ins[24:20]};
        end else begin
          legal = 1'b1;
          dec.sub_sra = f3 == 3'd2 || f3 == 3'd3;
          imm32 = {{20{ins[31]}}, ins[31:20]};
        end
      end
      is_op: begin
        dec.rs1_read = 1'b1;
        dec.rs2_read = 1'b1;
        dec.rd_write = 1'b1;
        if (f7 == 7'd0) begin
          legal = 1'b1;
          dec.sub_sra = f3 == 3'd2 || f3 == 3'd3;
        end else if (f7 == 7'b0100000) begin
          legal = f3 == 3'd0 || f3 == 3'd5;
          dec.sub_sra = 1'b1;
        end else if (f7 == 7'b0000001) begin
          legal = ENABLE_M != 0;
          dec.muldiv = 1'b1;
        end
      end
      default: ;
    endcase
    dec.imm = XLEN'($signed(imm32));
    if (!legal) begin
      dec.rs1_read  = 1'b0;
      dec.rs2_read  = 1'b0;
      dec.rd_write  = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 1'b0;
      dec.jump      = 1'b0;
      dec.muldiv    = 1'b0;
      dec.sub_sra   = 1'b0;
      dec.src1      = 2'd0;
      dec.src2      = 2'd0;
      dec.imm_sel   = 3'd0;
      dec.imm       = '0;
      dec.illegal   = 1'b1;
    end
    if (dec.rd == 5'd0) dec.rd_write = 1'b0;
  end

  assign hazard = (ENABLE_LU_STALL != 0)
    && ld_pend_q && hold_q
    && ((ctrl_q.rs1_read && ctrl_q.rs1 == ld_rd_q)
     || (ctrl_q.rs2_read && ctrl_q.rs2 == ld_rd_q));

  assign io.out_valid = hold_q && !hazard;
  assign io.in_ready  = !hold_q
                     || (io.out_ready && !hazard);
  assign accept = io.in_valid && io.in_ready;
  assign fire   = io.out_valid && io.out_ready;

  always_comb begin
    hold_d    = hold_q;
    ctrl_d    = ctrl_q;
    ld_pend_d = fire && ctrl_q.mem_read
             && ctrl_q.rd != 5'd0;
    ld_rd_d   = ld_pend_d ? ctrl_q.rd : ld_rd_q;
    if (accept) begin
      hold_d = 1'b1;
      ctrl_d = dec;
    end else if (fire) begin
      hold_d = 1'b0;
    end
    if (io.flush) begin
      hold_d    = 1'b0;
      ld_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q    <= 1'b0;
      ctrl_q    <= '0;
      ld_pend_q <= 1'b0;
      ld_rd_q   <= 5'd0;
    end else begin
      hold_q    <= hold_d;
      ctrl_q    <= ctrl_d;
      ld_pend_q <= ld_pend_d;
      ld_rd_q   <= ld_rd_d;
    end
  end

  assign io.pc_out          = ctrl_q.pc;
  assign io.rs1_addr_out    = ctrl_q.rs1;
  assign io.rs2_addr_out    = ctrl_q.rs2;
  assign io.rd_addr_out     = ctrl_q.rd;
  assign io.rs1_read_out    = ctrl_q.rs1_read;
  assign io.rs2_read_out    = ctrl_q.rs2_read;
  assign io.rd_write_out    = ctrl_q.rd_write;
  assign io.imm_out         = ctrl_q.imm;
  assign io.imm_sel_out     = ctrl_q.imm_sel;
  assign io.alu_op_out      = ctrl_q.alu_op;
  assign io.funct3_out      = ctrl_q.funct3;
  assign io.alu_sub_sra_out = ctrl_q.sub_sra;
  assign io.alu_src1_out    = ctrl_q.src1;
  assign io.alu_src2_out    = ctrl_q.src2;
  assign io.mem_read_out    = ctrl_q.mem_read;
  assign io.mem_write_out   = ctrl_q.mem_write;
  assign io.branch_out      = ctrl_q.branch;
  assign io.jump_out        = ctrl_q.jump;
  assign io.muldiv_out      = ctrl_q.muldiv;
  assign io.illegal_out     = ctrl_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: two instances share stimulus.
// a: ENABLE_M=0, stall on; b: ENABLE_M=1, stall off.
module tb_decode_stage;
  logic clk;
  logic reset;
  int   tests;
  int   fails;

  decode_stage_if #(.XLEN(32)) ifa ();
  decode_stage_if #(.XLEN(32)) ifb ();

  decode_stage #(
    .XLEN(32), .ENABLE_M(0), .ENABLE_LU_STALL(1)
  ) dut_a (
    .clk(clk), .reset(reset), .io(ifa.slave)
  );

  decode_stage #(
    .XLEN(32), .ENABLE_M(1), .ENABLE_LU_STALL(0)
  ) dut_b (
    .clk(clk), .reset(reset), .io(ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v,
                       input logic [31:0] ins,
                       input logic [31:0] pc,
                       input logic ordy,
                       input logic fl);
    ifa.in_valid  = v;
    ifa.instr_in  = ins;
    ifa.pc_in     = pc;
    ifa.out_ready = ordy;
    ifa.flush     = fl;
    ifb.in_valid  = v;
    ifb.instr_in  = ins;
    ifb.pc_in     = pc;
    ifb.out_ready = ordy;
    ifb.flush     = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] ADDI  = 32'h00500093;
  localparam logic [31:0] SUB   = 32'h402081B3;
  localparam logic [31:0] SRAI  = 32'h4021D213;
  localparam logic [31:0] LW    = 32'h0000A283;
  localparam logic [31:0] ADD   = 32'h00528333;
  localparam logic [31:0] BEQ   = 32'h00208463;
  localparam logic [31:0] BAD   = 32'hFFFFFFFF;
  localparam logic [31:0] MUL   = 32'h022083B3;
  localparam logic [31:0] BADLO = 32'h00500091;
  localparam logic [31:0] JAL   = 32'h010000EF;
  localparam logic [31:0] LUI   = 32'h123452B7;

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    drive(0, 32'd0, 32'd0, 1, 0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_valid", ifa.out_valid, 1'b0);
    chk("rst_ready", ifa.in_ready, 1'b1);
    chk("rst_pc", ifa.pc_out, 32'd0);
    chk("rst_imm", ifa.imm_out, 32'd0);
    chk("rst_rdw", ifa.rd_write_out, 1'b0);
    chk("rst_ldp", dut_a.ld_pend_q, 1'b0);

    drive(1, ADDI, 32'h100, 1, 0);
    tick();
    drive(0, 32'd0, 32'd0, 1, 0);
    chk("addi_v", ifa.out_valid, 1'b1);
    chk("addi_rs1r", ifa.rs1_read_out, 1'b1);
    chk("addi_rs2r", ifa.rs2_read_out, 1'b0);
    chk("addi_rdw", ifa.rd_write_out, 1'b1);
    chk("addi_imm", ifa.imm_out, 32'd5);
    chk("addi_src2", ifa.alu_src2_out, 2'd1);
    chk("addi_ill", ifa.illegal_out, 1'b0);
    chk("addi_pc", ifa.pc_out, 32'h100);
    tick();
    chk("addi_done", ifa.out_valid, 1'b0);

    drive(1, SUB, 32'h104, 1, 0);
    tick();
    drive(1, SRAI, 32'h108, 1, 0);
    chk("sub_v", ifa.out_valid, 1'b1);
    chk("sub_ss", ifa.alu_sub_sra_out, 1'b1);
    chk("sub_rdy", ifa.in_ready, 1'b1);
    tick();
    drive(0, 32'd0, 32'd0, 1, 0);
    chk("srai_v", ifa.out_valid, 1'b1);
    chk("srai_ss", ifa.alu_sub_sra_out, 1'b1);
    chk("srai_imm", ifa.imm_out, 32'd2);
    chk("srai_rd", ifa.rd_addr_out, 5'd4);
    tick();

    drive(1, LW, 32'h10C, 1, 0);
    tick();
    drive(1, ADD, 32'h110, 1, 0);
    chk("lw_v", ifa.out_valid, 1'b1);
    chk("lw_mr", ifa.mem_read_out, 1'b1);
    chk("lw_rdy", ifa.in_ready, 1'b1);
    tick();
    drive(0, 32'd0, 32'd0, 1, 0);
    chk("bub_v", ifa.out_valid, 1'b0);
    chk("bub_rdy", ifa.in_ready, 1'b0);
    chk("nostall_v", ifb.out_valid, 1'b1);
    chk("nostall_rd", ifb.rd_addr_out, 5'd6);
    tick();
    chk("add_v", ifa.out_valid, 1'b1);
    chk("add_rd", ifa.rd_addr_out, 5'd6);
    chk("add_rs1", ifa.rs1_addr_out, 5'd5);
    chk("b_idle", ifb.out_valid, 1'b0);
    tick();
    chk("add_done", ifa.out_valid, 1'b0);

    drive(1, BEQ, 32'h200, 0, 0);
    tick();
    drive(0, 32'd0, 32'd0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("beq_v", ifa.out_valid, 1'b1);
      chk("beq_rdy", ifa.in_ready, 1'b0);
      chk("beq_br", ifa.branch_out, 1'b1);
      chk("beq_imm", ifa.imm_out, 32'd8);
      chk("beq_pc", ifa.pc_out, 32'h200);
      tick();
    end
    drive(0, 32'd0, 32'd0, 1, 0);
    chk("beq_v2", ifa.out_valid, 1'b1);
    chk("beq_rdy2", ifa.in_ready, 1'b1);
    tick();
    chk("beq_once", ifa.out_valid, 1'b0);

    drive(1, BAD, 32'h300, 1, 0);
    tick();
    drive(1, MUL, 32'h304, 1, 0);
    chk("bad_v", ifa.out_valid, 1'b1);
    chk("bad_ill", ifa.illegal_out, 1'b1);
    chk("bad_rdw", ifa.rd_write_out, 1'b0);
    chk("bad_mw", ifa.mem_write_out, 1'b0);
    tick();
    drive(1, BADLO, 32'h308, 1, 0);
    chk("mul_v", ifa.out_valid, 1'b1);
    chk("mul_ill", ifa.illegal_out, 1'b1);
    chk("mul_rdw", ifa.rd_write_out, 1'b0);
    chk("mul_md", ifa.muldiv_out, 1'b0);
    chk("mulb_ill", ifb.illegal_out, 1'b0);
    chk("mulb_md", ifb.muldiv_out, 1'b1);
    chk("mulb_rdw", ifb.rd_write_out, 1'b1);
    tick();
    drive(0, 32'd0, 32'd0, 1, 0);
    chk("lo_ill", ifa.illegal_out, 1'b1);
    chk("lo_rs1r", ifa.rs1_read_out, 1'b0);
    tick();

    drive(1, LW, 32'h400, 1, 0);
    tick();
    drive(1, JAL, 32'h404, 1, 1);
    tick();
    drive(1, LUI, 32'h408, 1, 0);
    chk("fl_v", ifa.out_valid, 1'b0);
    chk("fl_ldp", dut_a.ld_pend_q, 1'b0);
    chk("fl_rdy", ifa.in_ready, 1'b1);
    tick();
    drive(0, 32'd0, 32'd0, 1, 0);
    chk("lui_v", ifa.out_valid, 1'b1);
    chk("lui_imm", ifa.imm_out, 32'h12345000);
    chk("lui_src1", ifa.alu_src1_out, 2'd2);
    chk("lui_jmp", ifa.jump_out, 1'b0);
    chk("lui_pc", ifa.pc_out, 32'h408);
    tick();
    chk("end_v", ifa.out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered RV32I/M instruction-decode stage that replaces the purely combinational control decode between fetch and execute. It accepts one instruction per cycle over a valid/ready handshake. It produces the full control word (operand reads, immediate, ALU selects, memory/branch/jump flags, illegal flag) in an output register. It inserts a one-cycle load-use bubble and supports pipeline flush.

## Interface
- XLEN, 32: datapath width for pc and sign-extended immediate (32 or 64).
- ENABLE_M, 1: 1 = decode MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU; 0 = flag them illegal.
- ENABLE_LU_STALL, 1: 1 = load-use bubble insertion; 0 = never stall.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  discard held instruction and hazard state.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  stage accepts this cycle.
- instr_in  in  32  instruction word.
- pc_in  in  XLEN  instruction address.
- out_valid  out  1  control word valid to execute.
- out_ready  in  1  execute accepts.
- pc_out  out  XLEN  registered pc.
- rs1_addr_out, rs2_addr_out, rd_addr_out  out  5 each  register indices.
- rs1_read_out, rs2_read_out, rd_write_out  out  1 each  register-file enables.
- imm_out  out  XLEN  sign-extended immediate.
- imm_sel_out  out  3  0 none, 1 I, 2 S, 3 B, 4 U, 5 J.
- alu_op_out  out  7  opcode field of instruction.
- funct3_out  out  3  funct3 field.
- alu_sub_sra_out  out  1  SUB/SRA/SRAI/SLT*/branch-compare select.
- alu_src1_out  out  2  0 rs1, 1 pc, 2 zero.
- alu_src2_out  out  2  0 rs2, 1 imm, 2 constant 4.
- mem_read_out, mem_write_out, branch_out, jump_out, muldiv_out, illegal_out  out  1 each.

## Operation
- Decoded classes: R-type ALU, I-type ALU, shifts-imm (SLLI/SRLI/SRAI, funct7 checked), loads LB/LH/LW/LBU/LHU, stores SB/SH/SW, branches (6), JAL, JALR, LUI, AUIPC, M-extension per ENABLE_M.
- rs1_read_out=1 for R, I-ALU, load, store, branch, JALR. rs2_read_out=1 for R, store, branch.
- rd_write_out=1 for R, I-ALU, load, JAL, JALR, LUI, AUIPC; forced 0 when rd=0.
- LUI: src1=zero, src2=imm. AUIPC: src1=pc, src2=imm. JAL/JALR: src1=pc, src2=4, jump_out=1.
- Illegal: any unlisted opcode/funct3/funct7 combination, or instr_in[1:0]!=2'b11. Still emitted with out_valid=1, illegal_out=1. All of rs*_read, rd_write, mem_*, branch, jump, muldiv are 0.
- Immediates are sign-extended to XLEN; U-type fills bits [11:0] with zero.
- Pipeline register:
  - in_ready = ~hold_valid | (out_ready & ~hazard).
  - An accept (in_valid & in_ready) loads the register.
  - With no accept, a downstream fire (out_valid & out_ready) clears hold_valid.
- Load-use: ld_pend/ld_rd are captured when a load with rd!=0 fires downstream; ld_pend lives exactly one cycle. hazard = ENABLE_LU_STALL & ld_pend & hold_valid & ((rs1_read & rs1==ld_rd) | (rs2_read & rs2==ld_rd)).
- While hazard: out_valid=0, in_ready=0, register holds. The next cycle ld_pend=0 and the instruction is presented normally.
- flush: next cycle hold_valid=0, ld_pend=0. flush overrides a same-cycle accept; the offered instruction is dropped and not re-requested.

## Timing
- Reset: out_valid=0, in_ready=1 in the first cycle after reset, ld_pend=0, all registered control fields 0, pc_out=0, imm_out=0.
- Latency: accept in cycle t -> out_valid and control word in cycle t+1.
- Throughput is 1/cycle when out_ready stays high and there is no hazard.
- out_valid with its payload holds stable until fire. Execute may drop out_ready at any time without loss.
- A load followed back-to-back by a dependent instruction costs exactly one bubble cycle. Independent successors cost none.
- reset and flush asserted together: reset behaviour applies.

## Test plan
- Reset, then ADDI x1,x0,5 (0x00500093), out_ready=1:
  - Next cycle out_valid=1, rs1_read=1, rs2_read=0, rd_write=1, imm_out=5, src2=1, illegal=0.
- Back-to-back SUB x3,x1,x2 then SRAI x4,x3,2 with out_ready=1:
  - Two consecutive valid outputs.
  - alu_sub_sra_out=1 for both; imm_out=2 on the second.
- LW x5,0(x1) then ADD x6,x5,x5:
  - LW fires, then one cycle of out_valid=0 and in_ready=0, then ADD valid.
  - With ENABLE_LU_STALL=0, there is no bubble.
- out_ready=0 for 3 cycles holding BEQ (0x00208463):
  - out_valid and payload are stable, in_ready=0, branch_out=1, imm_out=8.
  - The BEQ fires once when out_ready rises.
- 0xFFFFFFFF, then MUL with ENABLE_M=0:
  - Both emitted with illegal_out=1, rd_write=0, mem_*=0.
  - With ENABLE_M=1, MUL has muldiv_out=1 and illegal_out=0.
- flush in the same cycle as accepting JAL x1,16:
  - Next cycle out_valid=0 and ld_pend=0.
  - A LUI offered the following cycle is accepted with imm_out=upper<<12.
